// File: rtl/configure.sv
// Shared memory request/response types used by every core-to-memory port.
package configure;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

// File: rtl/fetchbuffer_wires.sv
// Types and state encoding shared by the fetch buffer controller and its FIFO.
package fetchbuffer_wires;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fbuf_entry_type;

    typedef struct packed {
        logic        redirect;
        logic        fence;
        logic [31:0] redirect_addr;
        logic        deq_ready;
    } fbuf_in_type;

    typedef struct packed {
        logic        instr_valid;
        logic [31:0] instr;
        logic [31:0] instr_pc;
    } fbuf_out_type;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FENCE_WAIT = 2'd1,
        ST_FENCE_REQ  = 2'd2,
        ST_FENCE_ACK  = 2'd3
    } fbuf_state_type;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetchbuffer_fifo.sv
// Small instruction FIFO: registered storage, push/pop/clear, occupancy count and head.
module fetchbuffer_fifo
    import fetchbuffer_wires::*;
#(
    parameter int fbuf_depth = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  fbuf_entry_type        wdata_i,
    output logic [fbuf_depth:0]   count_o,
    output logic                  valid_o,
    output fbuf_entry_type        head_o
);

    localparam int ENTRIES = 2 ** fbuf_depth;
    localparam logic [fbuf_depth-1:0] PTR_ONE = fbuf_depth'(1);

    logic [fbuf_depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [fbuf_depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [fbuf_depth:0]   count_q, count_d;
    fbuf_entry_type        mem_q [ENTRIES];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + {{fbuf_depth{1'b0}}, push_i} - {{fbuf_depth{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (rst && push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetchbuffer.sv
// Instruction fetch buffer: sequential ITIM fetch with one outstanding request,
// redirect/fence.i flushing and a small PC-tagged FIFO towards decode.
module fetchbuffer
    import configure::*;
    import fetchbuffer_wires::*;
#(
    parameter int          fbuf_depth = 2,
    parameter logic [31:0] reset_addr = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic        fence,
    input  logic [31:0] redirect_addr,
    input  logic        deq_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output mem_in_type  imem_in,
    input  mem_out_type imem_out
);

    localparam logic [fbuf_depth:0] FIFO_SLOTS = (fbuf_depth + 1)'(2 ** fbuf_depth);

    fbuf_state_type state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           inflight_q, inflight_d;
    logic           discard_q, discard_d;

    fbuf_in_type         fin;
    fbuf_out_type        fout;
    fbuf_entry_type      head;
    fbuf_entry_type      push_entry;
    logic [fbuf_depth:0] count;
    logic [fbuf_depth:0] count_next;
    logic                fifo_valid;
    logic                resp, inflight_after, flush, push, pop, issue;

    assign fin = '{redirect: redirect, fence: fence, redirect_addr: redirect_addr,
                   deq_ready: deq_ready};

    always_comb begin
        resp           = imem_out.mem_ready && inflight_q;
        inflight_after = inflight_q && !imem_out.mem_ready;
        pop            = fifo_valid && fin.deq_ready;
        flush          = (state_q == ST_RUN) && (fin.redirect || fin.fence);
        push           = (state_q == ST_RUN) && resp && !discard_q && !flush;
        count_next     = flush ? '0
                       : count + {{fbuf_depth{1'b0}}, push} - {{fbuf_depth{1'b0}}, pop};
        // Issuing against count_next lets a request go out in the same cycle as a pop.
        issue          = rst && (state_q == ST_RUN) && !flush && !inflight_after
                       && (count_next < FIFO_SLOTS);
        push_entry     = '{pc: fetch_pc_q, instr: imem_out.mem_rdata};

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_after || issue;
        discard_d  = resp ? 1'b0 : discard_q;

        imem_in           = '0;
        imem_in.mem_instr = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (fin.fence) begin
                    fetch_pc_d = word_align(fin.redirect_addr);
                    if (inflight_after) begin
                        discard_d = 1'b1;
                        state_d   = ST_FENCE_WAIT;
                    end else begin
                        state_d   = ST_FENCE_REQ;
                    end
                end else if (fin.redirect) begin
                    fetch_pc_d = word_align(fin.redirect_addr);
                    if (inflight_after) discard_d = 1'b1;
                end else if (push) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                imem_in.mem_valid = issue;
            end
            ST_FENCE_WAIT: begin
                if (fin.redirect) fetch_pc_d = word_align(fin.redirect_addr);
                if (resp) state_d = ST_FENCE_REQ;
            end
            ST_FENCE_REQ: begin
                if (fin.redirect) fetch_pc_d = word_align(fin.redirect_addr);
                imem_in.mem_valid = 1'b1;
                imem_in.mem_fence = 1'b1;
                state_d           = ST_FENCE_ACK;
            end
            ST_FENCE_ACK: begin
                if (fin.redirect) fetch_pc_d = word_align(fin.redirect_addr);
                if (imem_out.mem_ready) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // A same-cycle response advances fetch_pc, so the new request uses the next PC.
        imem_in.mem_addr = word_align(fetch_pc_d);
        if (!rst) imem_in = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= reset_addr;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetchbuffer_fifo #(
        .fbuf_depth (fbuf_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i (push_entry),
        .count_o (count),
        .valid_o (fifo_valid),
        .head_o  (head)
    );

    assign fout        = '{instr_valid: fifo_valid, instr: head.instr, instr_pc: head.pc};
    assign instr_valid = fout.instr_valid;
    assign instr       = fout.instr;
    assign instr_pc    = fout.instr_pc;

endmodule

// File: tb/tb_fetchbuffer.sv
// Self-checking bench for fetchbuffer: ITIM model, pop scoreboard, vector table and corner sequences.
module tb_fetchbuffer;
    import configure::*;

    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic        fence = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        deq_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    mem_in_type  imem_in;
    mem_out_type imem_out;

    always #5 clk = ~clk;

    fetchbuffer #(
        .fbuf_depth (2),
        .reset_addr (RST_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .fence         (fence),
        .redirect_addr (redirect_addr),
        .deq_ready     (deq_ready),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .imem_in       (imem_in),
        .imem_out      (imem_out)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] idata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    // ITIM model: latency counted from the request cycle to the ready cycle.
    int          lat = 1;
    int          fence_lat = 1;
    logic        busy = 1'b0;
    int          rem = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        pend_fence = 1'b0;
    logic        resp_fence = 1'b0;

    initial imem_out = '0;

    always @(posedge clk) begin
        imem_out.mem_ready <= 1'b0;
        imem_out.mem_rdata <= 32'h0;
        if (!rst) begin
            busy <= 1'b0;
        end else begin
            if (busy) begin
                if (rem <= 1) begin
                    imem_out.mem_ready <= 1'b1;
                    imem_out.mem_rdata <= pend_fence ? 32'h0 : idata(pend_addr);
                    resp_fence         <= pend_fence;
                    busy               <= 1'b0;
                end else begin
                    rem <= rem - 1;
                end
            end
            if (imem_in.mem_valid) begin
                if ((imem_in.mem_fence ? fence_lat : lat) <= 1) begin
                    imem_out.mem_ready <= 1'b1;
                    imem_out.mem_rdata <= imem_in.mem_fence ? 32'h0 : idata(imem_in.mem_addr);
                    resp_fence         <= imem_in.mem_fence;
                    busy               <= 1'b0;
                end else begin
                    busy       <= 1'b1;
                    rem        <= (imem_in.mem_fence ? fence_lat : lat) - 1;
                    pend_addr  <= imem_in.mem_addr;
                    pend_fence <= imem_in.mem_fence;
                end
            end
        end
    end

    // Monitor and scoreboard.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          req_cnt = 0;
    int          fence_cnt = 0;
    logic [31:0] last_req_addr = 32'h0;
    int          last_req_cyc = -1;
    int          last_fence_cyc = -1;
    int          last_resp_cyc = -1;
    int          last_ack_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (imem_in.mem_valid) begin
                if (imem_in.mem_fence) begin
                    fence_cnt++;
                    last_fence_cyc = cyc;
                end else begin
                    req_cnt++;
                    last_req_addr = imem_in.mem_addr;
                    last_req_cyc  = cyc;
                end
            end
            if (imem_out.mem_ready) begin
                if (resp_fence) last_ack_cyc = cyc;
                else            last_resp_cyc = cyc;
            end
            if (instr_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual pc=%h instr=%h required=no entry",
                             instr_pc, instr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_entry", {32'h0, instr_pc, instr}, {32'h0, e.pc, e.ins});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_q.push_back('{pc: a, ins: idata(a)});
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        deq_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 96'(exp_q.size()), 96'(0));
        deq_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_req(input string name, output logic [31:0] addr, output int rcyc,
                            input int budget);
        int start;
        int n;
        start = req_cnt;
        n = 0;
        while (req_cnt == start && n < budget) begin
            step();
            n++;
        end
        if (req_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no request required=request within %0d cycles",
                     name, budget);
            addr = 32'h0;
            rcyc = -1;
        end else begin
            addr = last_req_addr;
            rcyc = last_req_cyc;
        end
    endtask

    task automatic wait_ack(input int budget);
        int start;
        int n;
        start = last_ack_cyc;
        n = 0;
        while (last_ack_cyc == start && n < budget) begin
            step();
            n++;
        end
        check("fence_ack_seen", 96'(last_ack_cyc != start), 96'(1));
    endtask

    task automatic do_redirect(input logic [31:0] addr, output int rc);
        redirect      = 1'b1;
        redirect_addr = addr;
        rc            = cyc;
        step();
        redirect = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          n;
        logic [31:0] exp_pc0;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int rc, rq, rq2, p, st, sf;

        vecs[0] = '{32'h8000_0200, 1, 6, 32'h8000_0200};
        vecs[1] = '{32'hFFFF_FFF8, 1, 4, 32'hFFFF_FFF8};
        vecs[2] = '{32'h8000_0303, 2, 3, 32'h8000_0300};
        vecs[3] = '{32'h1234_5678, 3, 5, 32'h1234_5678};

        // Reset values, first request and 1 instr/cycle streaming.
        settle(3);
        check("rst_imem_in", 96'(imem_in), 96'(0));
        check("rst_outputs", {31'h0, instr_valid, instr_pc, instr}, 96'(0));
        expect_stream(RST_ADDR, 8);
        deq_ready = 1'b1;
        rst = 1'b1;
        rc = cyc;
        wait_req("first_req", a, rq, 10);
        check("first_req_addr", 96'(a), 96'(RST_ADDR));
        check("first_req_cycle", 96'(rq), 96'(rc));
        drain(40);
        check("stream_done_cycle", 96'(cyc), 96'(rc + 10));
        $display("txn reset_stream base=%h done_cycle=%0d", RST_ADDR, cyc);

        // Full FIFO: four requests then silence; a pop lets the next one out.
        settle(10);
        st = req_cnt;
        do_redirect(32'h8000_0100, rc);
        settle(11);
        check("full_req_count", 96'(req_cnt - st), 96'(4));
        check("full_no_valid", 96'(imem_in.mem_valid), 96'(0));
        expect_stream(32'h8000_0100, 4);
        deq_ready = 1'b1;
        p = cyc;
        wait_req("refill_req", a, rq, 10);
        check("refill_req_addr", 96'(a), 96'(32'h8000_0110));
        check("refill_req_cycle", 96'(rq), 96'(p));
        drain(20);
        $display("txn full_fifo requests=%0d refill_addr=%h", req_cnt - st, a);

        // Table of redirects.
        for (int i = 0; i < 4; i++) begin
            settle(10);
            lat = vecs[i].lat;
            do_redirect(vecs[i].addr, rc);
            expect_stream(vecs[i].exp_pc0, vecs[i].n);
            wait_req("vec_req", a, rq, 10);
            check("vec_req_addr", 96'(a), 96'(vecs[i].exp_pc0));
            check("vec_req_cycle", 96'(rq), 96'(rc + 1));
            drain(100);
            $display("txn vector %0d redirect=%h first_req=%h lat=%0d n=%0d",
                     i, vecs[i].addr, a, vecs[i].lat, vecs[i].n);
        end

        // Miss path with redirect while the request is outstanding.
        settle(10);
        lat = 20;
        do_redirect(32'h8000_2000, rc);
        wait_req("miss_req", a, rq, 10);
        check("miss_req_addr", 96'(a), 96'(32'h8000_2000));
        lat = 1;
        while (cyc < rc + 5) step();
        do_redirect(32'h8000_1000, rc);
        expect_stream(32'h8000_1000, 4);
        wait_req("after_miss_req", a, rq2, 40);
        check("after_miss_addr", 96'(a), 96'(32'h8000_1000));
        check("after_miss_cycle", 96'(rq2), 96'(rq + 20));
        drain(40);
        $display("txn miss_redirect next_req=%h at_cycle=%0d", a, rq2);

        // Redirect in the same cycle as mem_ready.
        settle(10);
        lat = 3;
        do_redirect(32'h8000_3000, rc);
        wait_req("same_req", a, rq, 10);
        lat = 1;
        while (cyc < rq + 3) step();
        do_redirect(32'h8000_4000, rc);
        check("same_cycle_dropped", 96'(instr_valid), 96'(0));
        expect_stream(32'h8000_4000, 3);
        wait_req("same_next_req", a, rq2, 10);
        check("same_next_addr", 96'(a), 96'(32'h8000_4000));
        check("same_next_cycle", 96'(rq2), 96'(rq + 4));
        drain(40);
        $display("txn redirect_on_ready next_req=%h", a);

        // fence.i while idle.
        settle(10);
        fence_lat = 64;
        sf = fence_cnt;
        st = req_cnt;
        fence = 1'b1;
        redirect_addr = 32'h8000_0040;
        rc = cyc;
        step();
        fence = 1'b0;
        wait_ack(100);
        check("fence_pulses", 96'(fence_cnt - sf), 96'(1));
        check("fence_req_cycle", 96'(last_fence_cyc), 96'(rc + 1));
        check("fence_ack_cycle", 96'(last_ack_cyc), 96'(rc + 65));
        check("fence_no_fetch", 96'(req_cnt - st), 96'(0));
        expect_stream(32'h8000_0040, 3);
        wait_req("post_fence_req", a, rq, 10);
        check("post_fence_addr", 96'(a), 96'(32'h8000_0040));
        check("post_fence_cycle", 96'(rq), 96'(last_ack_cyc + 1));
        drain(40);
        $display("txn fence_idle ack_cycle=%0d first_fetch=%h", last_ack_cyc, a);

        // fence together with redirect while a miss is outstanding.
        settle(10);
        lat = 20;
        fence_lat = 5;
        do_redirect(32'h8000_5000, rc);
        wait_req("fmiss_req", a, rq, 10);
        lat = 1;
        while (cyc < rq + 3) step();
        sf = fence_cnt;
        st = req_cnt;
        fence = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'h8000_6000;
        step();
        fence = 1'b0;
        redirect = 1'b0;
        wait_ack(60);
        check("fwait_pulses", 96'(fence_cnt - sf), 96'(1));
        check("fwait_fence_cycle", 96'(last_fence_cyc), 96'(rq + 21));
        check("fwait_ack_cycle", 96'(last_ack_cyc), 96'(rq + 26));
        check("fwait_no_fetch", 96'(req_cnt - st), 96'(0));
        expect_stream(32'h8000_6000, 3);
        wait_req("fwait_resume", a, rq2, 10);
        check("fwait_resume_addr", 96'(a), 96'(32'h8000_6000));
        check("fwait_resume_cycle", 96'(rq2), 96'(rq + 27));
        drain(40);
        $display("txn fence_with_miss fence_cycle=%0d resume=%h", last_fence_cyc, a);

        // Reset in the middle of an outstanding request.
        settle(10);
        lat = 5;
        do_redirect(32'h8000_7000, rc);
        settle(2);
        rst = 1'b0;
        step();
        check("midrst_imem_in", 96'(imem_in), 96'(0));
        check("midrst_outputs", {31'h0, instr_valid, instr_pc, instr}, 96'(0));
        lat = 1;
        rst = 1'b1;
        rc = cyc;
        expect_stream(RST_ADDR, 4);
        wait_req("midrst_req", a, rq, 10);
        check("midrst_req_addr", 96'(a), 96'(RST_ADDR));
        check("midrst_req_cycle", 96'(rq), 96'(rc));
        drain(40);
        $display("txn mid_reset restart=%h", a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
